// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the binary-to-BCD result converter.
//   BCD_WIDTH      default binary input width ({carry, sum} of the dot product)
//   BCD_DIGITS     default number of packed BCD output digits
//   BCD_ADD_THRESH digit value at or above which the add-3 correction applies
//   BCD_ADD_INC    correction increment
//   bcd_state_t    converter FSM state type with ST_IDLE / ST_SHIFT / ST_DONE
package bcd_pkg;

    localparam int unsigned BCD_WIDTH  = 17;
    localparam int unsigned BCD_DIGITS = 6;

    localparam logic [3:0] BCD_ADD_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD_INC    = 4'd3;

    typedef logic [1:0] bcd_state_t;

    localparam bcd_state_t ST_IDLE  = 2'd0;
    localparam bcd_state_t ST_SHIFT = 2'd1;
    localparam bcd_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
// Combinational double-dabble digit correction cell: dout = din >= 5 ? din + 3 : din.
// Ports:
//   din   input  [3:0]  BCD digit before correction
//   dout  output [3:0]  corrected digit (at most 12, so 4-bit arithmetic never wraps)
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADD_THRESH) ? (din + BCD_ADD_INC) : din;

endmodule

// File: rtl/bcd_result_converter.sv
// bcd_result_converter
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) for the
// dot-product result feeding the HEX5..HEX0 seven-segment drivers.
// Optional feature macro: BCD_LEADING_BLANK_EN enables the leading-zero blank mask;
// when undefined, blank is tied to zero and no blanking logic exists.
// Ports:
//   clk      input              rising-edge clock
//   reset    input              synchronous, active-high reset
//   start    input              conversion request, accepted only while ready=1
//   bin_in   input  [WIDTH-1:0] binary value, sampled on the accepting edge
//   ready    output             converter idle
//   valid    output             one-cycle pulse when bcd_out/blank update
//   bcd_out  output [4*DIGITS-1:0] packed digits, units in [3:0]
//   blank    output [DIGITS-1:0]   bit i=1 marks digit i as a leading zero
module bcd_result_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_WIDTH,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    bcd_state_t    state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          load_out;

    logic [BW-1:0] corr;
    logic [SW-1:0] shifted;

    // Correct every BCD digit of the register, then shift the whole thing left.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr_q[WIDTH + 4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    assign shifted = {corr, sr_q[WIDTH-1:0]} << 1;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        load_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {{BW{1'b0}}, bin_in};
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
                // Outputs are registered on the last shift edge so they are
                // visible together with valid during the DONE cycle.
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    bcd_d    = shifted[SW-1:WIDTH];
                    load_out = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign valid   = (state_q == ST_DONE);
    assign bcd_out = bcd_q;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [DIGITS-1:0] blank_q, blank_next;

    // Walk down from the top digit; a digit is blank while everything above and
    // including it is zero. Digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_next = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above    = zero_above && (shifted[WIDTH + 4*i +: 4] == 4'd0);
            blank_next[i] = (i > 0) && zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= BLANK_RST;
        end else if (load_out) begin
            blank_q <= blank_next;
        end
    end

    assign blank = blank_q;
`else
    logic unused_load_out;
    assign unused_load_out = load_out;
    assign blank           = '0;
`endif

endmodule

// File: tb/tb_bcd_result_converter.sv
module tb_bcd_result_converter;
    import bcd_pkg::*;

    localparam int W = BCD_WIDTH;
    localparam int D = BCD_DIGITS;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   bin_in;
    logic           ready;
    logic           valid;
    logic [4*D-1:0] bcd_out;
    logic [D-1:0]   blank;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_result_converter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .ready   (ready),
        .valid   (valid),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    typedef struct packed {
        logic [W-1:0]   bin;
        logic [4*D-1:0] bcd;
        logic [D-1:0]   blank;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Decimal reference: digits by repeated division.
    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digits i..D-1 are all zero exactly when v < 10**i.
    function automatic logic [D-1:0] ref_blank(input int unsigned v);
        logic [D-1:0] r;
        int unsigned p;
        r = '0;
`ifdef BCD_LEADING_BLANK_EN
        p = 10;
        for (int i = 1; i < D; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
`else
        p = v;
`endif
        return r;
    endfunction

    function automatic logic [D-1:0] tbl_blank(input logic [D-1:0] b);
`ifdef BCD_LEADING_BLANK_EN
        return b;
`else
        return (b & '0);
`endif
    endfunction

    // Waits for valid, counting edges since the caller's last edge; n=-1 on timeout.
    task automatic wait_valid(input int limit, output int n);
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                done = 1;
            end else if (n >= limit) begin
                n = -1;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    task automatic conv_check(input string nm, input logic [W-1:0] v,
                              input logic [4*D-1:0] eb, input logic [D-1:0] el);
        int n;
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = W'($urandom);
        wait_valid(40, n);
        chk({nm, " latency"}, n, W);
        if (n >= 0) begin
            chk({nm, " bcd"}, bcd_out, eb);
            chk({nm, " blank"}, blank, el);
            @(negedge clk);
            chk({nm, " valid one cycle"}, valid, 1'b0);
            chk({nm, " ready back"}, ready, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, t1, t2, pulses;
        logic ready_seen;
        logic [W-1:0] rv;

        tbl[0]  = '{17'd0,      24'h000000, 6'b111110};
        tbl[1]  = '{17'd131071, 24'h131071, 6'b000000};
        tbl[2]  = '{17'd12345,  24'h012345, 6'b100000};
        tbl[3]  = '{17'd99999,  24'h099999, 6'b100000};
        tbl[4]  = '{17'd500,    24'h000500, 6'b111000};
        tbl[5]  = '{17'd7,      24'h000007, 6'b111110};
        tbl[6]  = '{17'd42,     24'h000042, 6'b111100};
        tbl[7]  = '{17'd100000, 24'h100000, 6'b000000};
        tbl[8]  = '{17'd65536,  24'h065536, 6'b100000};
        tbl[9]  = '{17'd9,      24'h000009, 6'b111110};
        tbl[10] = '{17'd10,     24'h000010, 6'b111100};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset ready", ready, 1'b1);
        chk("reset valid", valid, 1'b0);
        chk("reset bcd", bcd_out, '0);
        chk("reset blank", blank, ref_blank(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            conv_check("tbl", tbl[i].bin, tbl[i].bcd, tbl_blank(tbl[i].blank));

        // start held high: two back-to-back conversions, 19 cycles apart
        bin_in = 17'd12345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        bin_in = 17'd99999;
        wait_valid(40, n);
        t1 = cyc;
        chk("b2b first latency", n, W);
        chk("b2b first bcd", bcd_out, 24'h012345);
        chk("b2b first blank", blank, tbl_blank(6'b100000));
        @(posedge clk);
        #1;
        wait_valid(40, n);
        t2 = cyc;
        chk("b2b second bcd", bcd_out, 24'h099999);
        chk("b2b second blank", blank, tbl_blank(6'b100000));
        chk("b2b period", t2 - t1, W + 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // starts during a busy conversion are dropped
        bin_in = 17'd500;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        bin_in     = 17'd1234;
        ready_seen = 1'b0;
        pulses     = 0;
        for (int k = 0; k < W + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start = (k == 3 || k == 10);
            @(negedge clk);
            if (ready) ready_seen = 1'b1;
            if (valid) pulses++;
        end
        chk("busy ready low", ready_seen, 1'b0);
        chk("busy bcd", bcd_out, 24'h000500);
        chk("busy blank", blank, tbl_blank(6'b111000));
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("busy single valid", pulses, 1);
        @(posedge clk);
        #1;

        // reset mid-conversion aborts without a valid pulse
        bin_in = 17'd4242;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort ready", ready, 1'b1);
        chk("abort valid", valid, 1'b0);
        chk("abort bcd", bcd_out, '0);
        chk("abort blank", blank, ref_blank(0));
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("abort no valid", pulses, 0);
        @(posedge clk);
        #1;
        conv_check("after abort", 17'd7, 24'h000007, tbl_blank(6'b111110));

        // random sweep against the decimal model
        for (int k = 0; k < 1000; k++) begin
            rv = W'($urandom_range(0, (1 << W) - 1));
            conv_check("rand", rv, ref_bcd(rv), ref_blank(rv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
